// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between the
// instruction-fetch port and the load/store data port. One transaction is
// outstanding at a time. The arbiter issues the access, waits the fixed
// memory latency and routes the response back to the requester that owns it.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter values the latency counter and byte lanes cannot support.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT must be within 1..8");
    end
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("mem_arbiter: DATA_W must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  owner_t           last_owner_reg, last_owner_next;
  logic             owner_we_reg, owner_we_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             win_d;
  logic             resp_due;

  // State register; reset drops any in-flight access so its response never appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      owner_we_reg   <= 1'b0;
      cnt_reg        <= '0;
      last_owner_reg <= OWN_IF;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      owner_we_reg   <= owner_we_next;
      cnt_reg        <= cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Arbitration, memory issue and response routing; every output is forced
  // low while rst_n is asserted, including the combinational grant path.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    owner_we_next   = owner_we_reg;
    cnt_next        = cnt_reg;
    last_owner_next = last_owner_reg;
    if_gnt          = 1'b0;
    if_rvalid       = 1'b0;
    if_rdata        = '0;
    d_gnt           = 1'b0;
    d_rvalid        = 1'b0;
    d_rdata         = '0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_be          = '0;
    // Data wins when alone, or on contention when fetch went last.
    win_d           = d_req && (!if_req || last_owner_reg == OWN_IF);
    resp_due        = (cnt_reg == LAT_CNT);

    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          if (if_req || d_req) begin
            mem_en = 1'b1;
            if (win_d) begin
              d_gnt     = 1'b1;
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
              mem_be    = d_we ? d_be : '1;
            end else begin
              if_gnt    = 1'b1;
              mem_addr  = if_addr;
              mem_be    = '1;
            end
            state_next      = BUSY;
            cnt_next        = CNT_ONE;
            owner_next      = win_d ? OWN_D : OWN_IF;
            owner_we_next   = win_d && d_we;
            last_owner_next = win_d ? OWN_D : OWN_IF;
          end
        end
        BUSY: begin
          if (resp_due) begin
            // Counter stops here rather than wrapping; the response pulses once.
            state_next = IDLE;
            cnt_next   = '0;
            if (owner_reg == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = owner_we_reg ? '0 : mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one synchronous single-port memory between the core's instruction-fetch port and its load/store data port. At most one transaction is outstanding at a time. The arbiter grants one requester, issues the access, counts the fixed memory latency and returns the response to the granted requester. It sits between the core pipeline (fetch/LSU) and the unified instruction/data memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..8

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_be  in  DATA_W/8  byte enables (writes)
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data response (read data or write ack), one-cycle pulse
d_rdata  out  DATA_W  read data; 0 for write acks
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables; all-ones for reads
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states: IDLE, BUSY. Registers: state, owner (IF/D), owner_we, lat counter of width clog2(MEM_LAT+1), last_owner.
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, owner=IF, last_owner=IF. All outputs are 0 while rst_n is low, including combinational gnt/mem_* outputs. Any in-flight response is dropped and never delivered.
- IDLE with no request: all gnt/mem_*/rvalid outputs are 0.
- IDLE with a request: the winner gets gnt=1 combinationally in the same cycle. mem_en=1 in that cycle, and mem_we/mem_addr/mem_wdata/mem_be are driven from the winner's inputs in that cycle. Fetch: mem_we=0, mem_be=all-ones. On the next edge: state=BUSY, counter=1, owner and owner_we latched, last_owner=winner.
- Arbitration: a single requester always wins. On contention, the requester that is not last_owner wins. After reset last_owner=IF, so data wins the first contention; sustained contention alternates D,I,D,I.
- BUSY: no gnt, mem_en=0. Counter increments each cycle. In the cycle where (cycles since issue)==MEM_LAT, the owner's rvalid=1 for exactly one cycle. In that cycle owner rdata=mem_rdata (reads) or 0 (write ack), and state returns to IDLE on the next edge.
- Throughput: one transaction per MEM_LAT+1 cycles. A request is never granted in the rvalid cycle.
- The non-owner's rvalid is always 0, and its rdata is 0.
- Requests that drop before gnt are allowed. Request inputs are ignored in BUSY.
- Counter never wraps; MEM_LAT outside 1..8 is an elaboration error.

Test Plan:
1. MEM_LAT=2; fetch only, if_req=1, if_addr=0x100 at cycle T -> if_gnt=1, mem_en=1, mem_addr=0x100, mem_we=0 at T. if_rvalid=1 at T+2 with if_rdata=mem_rdata (model returns 0xDEADBEEF). No gnt at T+1, T+2.
2. Immediately after reset, if_req and d_req both high (d_addr=0x200) -> d_gnt at T, if_gnt=0. if_gnt at T+MEM_LAT+1.
3. Both requests held high for 6 grants -> grant sequence D,I,D,I,D,I. Each gnt is spaced MEM_LAT+1 cycles apart. rvalid goes only to the matching owner.
4. Data write d_we=1, d_addr=0x40, d_wdata=0x12345678, d_be=4'b0011 -> mem_we=1, mem_be=0011, mem_wdata=0x12345678 at T. d_rvalid=1 at T+MEM_LAT with d_rdata=0. if_rvalid stays 0.
5. MEM_LAT=3; assert rst_n=0 at T+1 after a fetch grant -> all outputs 0 immediately. After release, no if_rvalid occurs, and a new d_req is granted on the first cycle after release.
6. Sweep MEM_LAT=1 and 8 with random req traffic -> rvalid exactly MEM_LAT cycles after each gnt. No mem_en while BUSY. Never two outstanding accesses.
